// File: rtl/code_lock_fsm.sv
// -----------------------------------------------------------------------------
// code_lock_fsm
//
// Combination-lock controller. Rising edges on the debounced button levels
// are turned into press events. In ENTRY, CODE_LEN events are compared
// against the stored code. A wrong symbol does not end the attempt early, so
// the failing position is never revealed. Consecutive failed attempts are
// counted, and reaching MAX_FAIL starts a timed lockout. Once unlocked, the
// lock relocks by itself after UNLOCK_CYC idle cycles. While unlocked, the
// code can be reprogrammed through a shadow register. A reset restores the
// built-in CODE.
//
// Ports
//   clk        in   system clock
//   RST_BTN    in   synchronous active-high reset
//   btn        in   NUM_BTN debounced button levels, 1 = pressed
//   prog_en    in   level, requests reprogramming while unlocked
//   led        out  1 = unlocked (UNLOCKED or PROGRAM)
//   locked_out out  1 = lockout active, button input ignored
//   bcd        out  entry / programming progress digit
//   fail_cnt   out  consecutive failed attempts
//   mode       out  00 ENTRY, 01 UNLOCKED, 10 LOCKOUT, 11 PROGRAM
// All outputs are registered. A press changes them on the same clock edge
// that samples it.
// -----------------------------------------------------------------------------
module code_lock_fsm #(
    parameter int NUM_BTN     = 4,
    parameter int CODE_LEN    = 4,
    parameter logic [CODE_LEN*((NUM_BTN > 1) ? $clog2(NUM_BTN) : 1)-1:0] CODE = 8'h1B,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 1000,
    parameter int UNLOCK_CYC  = 2000
) (
    input  logic               clk,
    input  logic               RST_BTN,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               prog_en,
    output logic               led,
    output logic               locked_out,
    output logic [3:0]         bcd,
    output logic [3:0]         fail_cnt,
    output logic [1:0]         mode
);

    localparam int SYM_W   = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int CW      = CODE_LEN * SYM_W;
    localparam int MAX_CYC = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'b00,
        ST_UNLOCKED = 2'b01,
        ST_LOCKOUT  = 2'b10,
        ST_PROGRAM  = 2'b11
    } state_t;

    state_t             state_q,    state_d;
    logic [NUM_BTN-1:0] btn_prev_q;
    logic [3:0]         idx_q,      idx_d;
    logic               mism_q,     mism_d;
    logic [TMR_W-1:0]   timer_q,    timer_d;
    logic [3:0]         fail_q,     fail_d;
    logic [CW-1:0]      code_q,     code_d;
    logic [CW-1:0]      shadow_q,   shadow_d;
    logic               led_q,      led_d;
    logic               locked_q,   locked_d;
    logic [3:0]         bcd_q,      bcd_d;

    logic [NUM_BTN-1:0] press_s;
    logic               event_s;
    logic               onehot_s;
    logic [SYM_W-1:0]   sym_s;
    logic [SYM_W-1:0]   code_sym_s;
    logic               last_s;
    logic               sym_ok_s;

    // Bit index of the highest set bit. It is only meaningful for one-hot input.
    function automatic logic [SYM_W-1:0] sym_of(input logic [NUM_BTN-1:0] p);
        logic [SYM_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (p[i]) begin
                s = SYM_W'(i);
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    // Press detection and symbol decode of the current event.
    always_comb begin
        press_s    = btn & ~btn_prev_q;
        event_s    = |press_s;
        onehot_s   = event_s && ((press_s & (press_s - NUM_BTN'(1))) == '0);
        sym_s      = sym_of(press_s);
        code_sym_s = code_q[int'(idx_q) * SYM_W +: SYM_W];
        last_s     = (idx_q == 4'(CODE_LEN - 1));
        sym_ok_s   = onehot_s && (sym_s == code_sym_s);
    end

    // Next-state and next-output logic for all four modes.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mism_d   = mism_q;
        timer_d  = timer_q;
        fail_d   = fail_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        led_d    = led_q;
        locked_d = locked_q;
        bcd_d    = bcd_q;

        case (state_q)
            ST_ENTRY: begin
                led_d    = 1'b0;
                locked_d = 1'b0;
                timer_d  = '0;
                if (event_s) begin
                    if (last_s) begin
                        idx_d  = 4'd0;
                        bcd_d  = 4'd0;
                        mism_d = 1'b0;
                        // The last symbol is judged together with the
                        // earlier ones, so the attempt passes or fails as one.
                        if (!mism_q && sym_ok_s) begin
                            state_d = ST_UNLOCKED;
                            fail_d  = 4'd0;
                            led_d   = 1'b1;
                        end else if ((fail_q + 4'd1) == 4'(MAX_FAIL)) begin
                            state_d  = ST_LOCKOUT;
                            fail_d   = fail_q + 4'd1;
                            locked_d = 1'b1;
                        end else begin
                            fail_d = fail_q + 4'd1;
                        end
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        bcd_d  = idx_q + 4'd1;
                        mism_d = mism_q | ~sym_ok_s;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end

            ST_UNLOCKED: begin
                led_d    = 1'b1;
                locked_d = 1'b0;
                bcd_d    = 4'd0;
                if (prog_en) begin
                    // prog_en wins over a timeout on the same edge.
                    state_d  = ST_PROGRAM;
                    timer_d  = '0;
                    idx_d    = 4'd0;
                    shadow_d = code_q;
                end else if (event_s) begin
                    timer_d = '0;
                end else if (timer_q == TMR_W'(UNLOCK_CYC - 1)) begin
                    state_d = ST_ENTRY;
                    led_d   = 1'b0;
                    timer_d = '0;
                    idx_d   = 4'd0;
                    mism_d  = 1'b0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_PROGRAM: begin
                led_d    = 1'b1;
                locked_d = 1'b0;
                timer_d  = '0;
                if (!prog_en) begin
                    // Abandoned programming leaves code_q untouched.
                    state_d = ST_UNLOCKED;
                    idx_d   = 4'd0;
                    bcd_d   = 4'd0;
                end else if (onehot_s) begin
                    shadow_d[int'(idx_q) * SYM_W +: SYM_W] = sym_s;
                    if (last_s) begin
                        code_d  = shadow_d;
                        state_d = ST_ENTRY;
                        led_d   = 1'b0;
                        fail_d  = 4'd0;
                        idx_d   = 4'd0;
                        bcd_d   = 4'd0;
                        mism_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        bcd_d = idx_q + 4'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end

            ST_LOCKOUT: begin
                led_d    = 1'b0;
                locked_d = 1'b1;
                bcd_d    = 4'd0;
                if (timer_q == TMR_W'(LOCKOUT_CYC - 1)) begin
                    state_d  = ST_ENTRY;
                    locked_d = 1'b0;
                    fail_d   = 4'd0;
                    timer_d  = '0;
                    idx_d    = 4'd0;
                    mism_d   = 1'b0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            default: begin
                state_d  = ST_ENTRY;
                idx_d    = 4'd0;
                mism_d   = 1'b0;
                timer_d  = '0;
                fail_d   = 4'd0;
                led_d    = 1'b0;
                locked_d = 1'b0;
                bcd_d    = 4'd0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RST_BTN) begin
            state_q    <= ST_ENTRY;
            // Set to all ones so that a button held through reset is not seen as a press.
            btn_prev_q <= '1;
            idx_q      <= 4'd0;
            mism_q     <= 1'b0;
            timer_q    <= '0;
            fail_q     <= 4'd0;
            code_q     <= CODE;
            shadow_q   <= CODE;
            led_q      <= 1'b0;
            locked_q   <= 1'b0;
            bcd_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            btn_prev_q <= btn;
            idx_q      <= idx_d;
            mism_q     <= mism_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            code_q     <= code_d;
            shadow_q   <= shadow_d;
            led_q      <= led_d;
            locked_q   <= locked_d;
            bcd_q      <= bcd_d;
        end
    end

    assign led        = led_q;
    assign locked_out = locked_q;
    assign bcd        = bcd_q;
    assign fail_cnt   = fail_q;
    assign mode       = state_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// -----------------------------------------------------------------------------
// tb_code_lock_fsm
//
// Bench for code_lock_fsm with its default parameters. A behavioural model
// keeps the entered symbols in queues and judges each attempt as a whole.
// It counts cycles spent in each mode. A compare process checks every output
// against the model on every falling edge. Directed sequences also check
// hand-computed literal values: progress digits, fail counts and the exact
// lengths of the lockout and unlock windows.
// -----------------------------------------------------------------------------
module tb_code_lock_fsm;

    localparam int PER = 10;

    logic       clk = 1'b0;
    logic       RST_BTN = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic       prog_en = 1'b0;
    logic       led;
    logic       locked_out;
    logic [3:0] bcd;
    logic [3:0] fail_cnt;
    logic [1:0] mode;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    code_lock_fsm dut (
        .clk        (clk),
        .RST_BTN    (RST_BTN),
        .btn        (btn),
        .prog_en    (prog_en),
        .led        (led),
        .locked_out (locked_out),
        .bcd        (bcd),
        .fail_cnt   (fail_cnt),
        .mode       (mode)
    );

    initial forever #(PER / 2) clk = ~clk;

    // ---------------- behavioural model ----------------
    // Modes: 0 entry, 1 unlocked, 2 lockout, 3 program.
    int         m_mode = 0;
    int         m_fail = 0;
    int         m_cnt  = 0;
    int         m_code[4] = '{3, 2, 1, 0};
    int         m_ent[$];
    int         m_prg[$];
    logic [3:0] m_prev = 4'b1111;

    task automatic model_step();
        logic [3:0] pr;
        int         sym;
        bit         single;
        bit         ok;
        if (RST_BTN) begin
            m_mode = 0; m_fail = 0; m_cnt = 0;
            m_code = '{3, 2, 1, 0};
            m_ent.delete(); m_prg.delete();
            m_prev = 4'b1111;
        end else begin
            pr     = btn & ~m_prev;
            m_prev = btn;
            single = ($countones(pr) == 1);
            sym    = -1;
            for (int i = 0; i < 4; i++) if (single && pr[i]) sym = i;
            case (m_mode)
                0: if (pr != 4'b0000) begin
                    m_ent.push_back(sym);
                    if (m_ent.size() == 4) begin
                        ok = 1'b1;
                        for (int i = 0; i < 4; i++) if (m_ent[i] != m_code[i]) ok = 1'b0;
                        m_ent.delete();
                        if (ok) begin
                            m_mode = 1; m_fail = 0; m_cnt = 0;
                        end else begin
                            m_fail++;
                            if (m_fail == 3) begin m_mode = 2; m_cnt = 0; end
                        end
                    end
                end
                1: if (prog_en) begin
                    m_mode = 3; m_prg.delete();
                end else if (pr != 4'b0000) begin
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == 2000) m_mode = 0;
                end
                2: begin
                    m_cnt++;
                    if (m_cnt == 1000) begin m_mode = 0; m_fail = 0; end
                end
                default: if (!prog_en) begin
                    m_mode = 1; m_cnt = 0; m_prg.delete();
                end else if (single) begin
                    m_prg.push_back(sym);
                    if (m_prg.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_code[i] = m_prg[i];
                        m_prg.delete();
                        m_mode = 0; m_fail = 0;
                    end
                end
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge.
    initial forever begin
        int e_bcd;
        int exp_v;
        int act_v;
        @(negedge clk);
        if (chk_en) begin
            e_bcd = (m_mode == 0) ? m_ent.size() : (m_mode == 3) ? m_prg.size() : 0;
            exp_v = (((m_mode == 1) || (m_mode == 3)) ? 1 : 0) << 11;
            exp_v = exp_v | ((m_mode == 2) ? 1 : 0) << 10;
            exp_v = exp_v | (e_bcd << 6) | (m_fail << 2) | m_mode;
            act_v = int'({led, locked_out, bcd, fail_cnt, mode});
            chk("cycle", act_v, exp_v);
        end
    end

    // ---------------- stimulus helpers ----------------
    int     sn_bcd, sn_led, sn_lock, sn_fail, sn_mode;
    longint sn_time;

    task automatic snap();
        sn_bcd  = int'(bcd);
        sn_led  = int'(led);
        sn_lock = int'(locked_out);
        sn_fail = int'(fail_cnt);
        sn_mode = int'(mode);
        sn_time = $time;
    endtask

    // Called on a falling edge: one cycle high, then two cycles low.
    task automatic press_mask(input logic [3:0] m);
        btn = m;
        @(negedge clk);
        snap();
        btn = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic enter4(input string nm, input int a, input int b, input int c,
                          input int d, input bit prog_chk);
        int s[4];
        s = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            press_mask(4'(1 << s[i]));
            if (prog_chk && i < 3) chk({nm, "_bcd"}, sn_bcd, i + 1);
        end
    endtask

    task automatic do_reset();
        RST_BTN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        RST_BTN = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
    endtask

    task automatic wait_low(input string nm, input bit use_lock, output longint t);
        bit done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if ((use_lock ? locked_out : led) == 1'b0) done = 1'b1;
        end
        t = $time;
        if (!done) chk({nm, "_timeout"}, 0, 1);
    endtask

    longint t0, t1;

    initial begin
        // S1: reset values
        do_reset();
        chk("rst_mode", int'(mode), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_bcd", int'(bcd), 0);
        chk("rst_fail", int'(fail_cnt), 0);
        chk("rst_lock", int'(locked_out), 0);

        // S2: correct code, then idle relock after exactly 2000 cycles
        enter4("s2", 3, 2, 1, 0, 1'b1);
        chk("s2_led", sn_led, 1);
        chk("s2_mode", sn_mode, 1);
        chk("s2_bcd", sn_bcd, 0);
        chk("s2_fail", sn_fail, 0);
        t0 = sn_time;
        wait_low("s2", 1'b0, t1);
        chk("s2_idle_len", int'((t1 - t0) / PER), 2000);
        chk("s2_relock_mode", int'(mode), 0);

        // S3: wrong attempt, then correct
        enter4("s3w", 3, 0, 1, 0, 1'b1);
        chk("s3w_bcd", sn_bcd, 0);
        chk("s3w_led", sn_led, 0);
        chk("s3w_fail", sn_fail, 1);
        chk("s3w_mode", sn_mode, 0);
        enter4("s3c", 3, 2, 1, 0, 1'b1);
        chk("s3c_mode", sn_mode, 1);
        chk("s3c_fail", sn_fail, 0);

        // S4: a press at cycle 1500 restarts the relock count
        repeat (1497) @(negedge clk);
        press_mask(4'b0001);
        chk("s4_still_led", sn_led, 1);
        t0 = sn_time;
        wait_low("s4", 1'b0, t1);
        chk("s4_idle_len", int'((t1 - t0) / PER), 2000);

        // S5: three failures, then a lockout of exactly 1000 cycles that ignores the correct code
        enter4("s5a", 0, 0, 0, 0, 1'b1);
        chk("s5a_fail", sn_fail, 1);
        enter4("s5b", 0, 0, 0, 0, 1'b1);
        chk("s5b_fail", sn_fail, 2);
        enter4("s5c", 0, 0, 0, 0, 1'b1);
        chk("s5c_lock", sn_lock, 1);
        chk("s5c_mode", sn_mode, 2);
        chk("s5c_fail", sn_fail, 3);
        t0 = sn_time;
        enter4("s5i", 3, 2, 1, 0, 1'b0);
        chk("s5i_mode", sn_mode, 2);
        chk("s5i_bcd", sn_bcd, 0);
        wait_low("s5", 1'b1, t1);
        chk("s5_lock_len", int'((t1 - t0) / PER), 1000);
        chk("s5_exit_mode", int'(mode), 0);
        chk("s5_exit_fail", int'(fail_cnt), 0);

        // S6: program 0,0,1,1
        enter4("s6u", 3, 2, 1, 0, 1'b1);
        chk("s6u_mode", sn_mode, 1);
        prog_en = 1'b1;
        @(negedge clk);
        chk("s6_prog_mode", int'(mode), 3);
        chk("s6_prog_led", int'(led), 1);
        enter4("s6p", 0, 0, 1, 1, 1'b1);
        chk("s6p_mode", sn_mode, 0);
        chk("s6p_led", sn_led, 0);
        prog_en = 1'b0;
        enter4("s6old", 3, 2, 1, 0, 1'b1);
        chk("s6old_fail", sn_fail, 1);
        enter4("s6new", 0, 0, 1, 1, 1'b1);
        chk("s6new_mode", sn_mode, 1);
        chk("s6new_fail", sn_fail, 0);

        // S7: abandon programming after two symbols; the code is kept
        prog_en = 1'b1;
        @(negedge clk);
        press_mask(4'b0100);
        chk("s7_bcd1", sn_bcd, 1);
        press_mask(4'b0100);
        chk("s7_bcd2", sn_bcd, 2);
        prog_en = 1'b0;
        @(negedge clk);
        chk("s7_back_mode", int'(mode), 1);
        chk("s7_back_bcd", int'(bcd), 0);
        t0 = $time;
        wait_low("s7", 1'b0, t1);
        chk("s7_idle_len", int'((t1 - t0) / PER), 2000);
        enter4("s7k", 0, 0, 1, 1, 1'b1);
        chk("s7k_mode", sn_mode, 1);

        // S8: reset restores the built-in code
        do_reset();
        chk("s8_mode", int'(mode), 0);
        enter4("s8p", 0, 0, 1, 1, 1'b1);
        chk("s8p_fail", sn_fail, 1);
        enter4("s8c", 3, 2, 1, 0, 1'b1);
        chk("s8c_mode", sn_mode, 1);

        // S9: a button held through reset release gives no event
        btn = 4'b1000;
        do_reset();
        @(negedge clk);
        chk("s9_bcd", int'(bcd), 0);
        btn = 4'b0000;
        @(negedge clk);
        enter4("s9c", 3, 2, 1, 0, 1'b1);
        chk("s9c_mode", sn_mode, 1);

        // S10: multi-hot press counts as a mismatch in ENTRY and is ignored in PROGRAM
        do_reset();
        press_mask(4'b1000);
        press_mask(4'b0110);
        chk("s10_mh_bcd", sn_bcd, 2);
        press_mask(4'b0010);
        press_mask(4'b0001);
        chk("s10_mh_fail", sn_fail, 1);
        chk("s10_mh_mode", sn_mode, 0);
        enter4("s10u", 3, 2, 1, 0, 1'b1);
        chk("s10u_mode", sn_mode, 1);
        prog_en = 1'b1;
        @(negedge clk);
        press_mask(4'b0001);
        press_mask(4'b0110);
        chk("s10p_mh_bcd", sn_bcd, 1);
        chk("s10p_mh_mode", sn_mode, 3);
        press_mask(4'b0010);
        press_mask(4'b0100);
        press_mask(4'b1000);
        chk("s10p_done_mode", sn_mode, 0);
        prog_en = 1'b0;
        enter4("s10n", 0, 1, 2, 3, 1'b1);
        chk("s10n_mode", sn_mode, 1);

        // S11: reset after two entry presses clears progress
        do_reset();
        press_mask(4'b1000);
        press_mask(4'b0100);
        chk("s11_bcd2", sn_bcd, 2);
        RST_BTN = 1'b1;
        @(negedge clk);
        chk("s11_rst_bcd", int'(bcd), 0);
        RST_BTN = 1'b0;
        @(negedge clk);
        enter4("s11c", 3, 2, 1, 0, 1'b1);
        chk("s11c_mode", sn_mode, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
